branch_resolution_controller: RTL and testbench

- Sequences the branch waterfall queue, which holds up to 3 in-flight branch predictions, each paired with its mispredict (alternate) address.
- Accepts new predictions from fetch and resolved outcomes from execute, and drives the queue's load/update/correct strobes.
- Compares each resolved outcome against the queue head; on a mispredict it issues a one-cycle redirect and a timed pipeline flush.
- Also clears the reset-less queue while reset is held, and applies fetch backpressure when the queue is full.

---
 rtl/branch_resolution_controller.sv | 161 ++++++++++++++++
 tb/tb_branch_resolution_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_controller.sv
// Sequencing controller for the branch waterfall queue: load/update/correct strobes,
// mispredict redirect and timed flush. Optional event counters under BRANCH_STATS_EN.
module branch_resolution_controller #(
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        fetch_branch_valid,
    input  logic        fetch_prediction,
    input  logic [15:0] fetch_alt_address,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic        q_prediction,
    input  logic [15:0] q_mispredict_address,
    output logic        q_stall,
    output logic        q_load_prediction,
    output logic        q_update_predictions,
    output logic        q_correct_prediction,
    output logic        q_prediction_in,
    output logic [15:0] q_mispredict_address_in,
    output logic        fetch_hold,
    output logic        redirect_valid,
    output logic [15:0] redirect_address,
    output logic        flush,
    output logic [1:0]  inflight_count,
    output logic        protocol_err,
    output logic [15:0] stat_resolved,
    output logic [15:0] stat_mispredicts
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        RUN_S   = 1'b0,
        FLUSH_S = 1'b1
    } state_t;

    state_t         state_r;
    logic [1:0]     count_r;
    logic [FCW-1:0] flush_cnt_r;
    logic           redirect_valid_r;
    logic [15:0]    redirect_address_r;
    logic           flush_r;
    logic           protocol_err_r;

    logic           accept_s;
    logic           mispredict_s;
    logic           full_s;
    logic           load_s;

    assign full_s       = (count_r == 2'(DEPTH)) && (state_r == RUN_S);
    assign accept_s     = resolve_valid && (count_r != 2'd0);
    assign mispredict_s = accept_s && (resolve_taken != q_prediction);
    assign load_s       = fetch_branch_valid && !full_s && !mispredict_s;

    assign q_stall                 = stall;
    assign q_prediction_in         = fetch_prediction;
    assign q_mispredict_address_in = fetch_alt_address;
    assign fetch_hold              = full_s;
    assign redirect_valid          = redirect_valid_r;
    assign redirect_address        = redirect_address_r;
    assign flush                   = flush_r;
    assign inflight_count          = count_r;
    assign protocol_err            = protocol_err_r;

    // Queue strobes; reset holds the reset-less queue in a clearing update
    always_comb begin
        q_update_predictions = 1'b0;
        q_correct_prediction = 1'b0;
        q_load_prediction    = 1'b0;
        if (!rst_n) begin
            q_update_predictions = 1'b1;
        end else if (stall) begin
            q_update_predictions = 1'b0;
        end else if (state_r == RUN_S) begin
            q_update_predictions = accept_s;
            q_correct_prediction = !mispredict_s;
            q_load_prediction    = load_s;
        end else begin
            q_update_predictions = 1'b0;
        end
    end

    // Controller state: occupancy, redirect, flush timing and protocol flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r            <= RUN_S;
            count_r            <= 2'd0;
            flush_cnt_r        <= '0;
            redirect_valid_r   <= 1'b0;
            redirect_address_r <= 16'h0000;
            flush_r            <= 1'b0;
            protocol_err_r     <= 1'b0;
        end else if (!stall) begin
            case (state_r)
                RUN_S: begin
                    if (resolve_valid && (count_r == 2'd0)) begin
                        protocol_err_r <= 1'b1;
                    end
                    if (mispredict_s) begin
                        count_r            <= 2'd0;
                        redirect_address_r <= q_mispredict_address;
                        redirect_valid_r   <= 1'b1;
                        flush_r            <= 1'b1;
                        flush_cnt_r        <= FCW'(FLUSH_CYCLES - 1);
                        state_r            <= FLUSH_S;
                    end else begin
                        redirect_valid_r <= 1'b0;
                        if (load_s && !accept_s) begin
                            count_r <= count_r + 2'd1;
                        end else if (accept_s && !load_s) begin
                            count_r <= count_r - 2'd1;
                        end
                    end
                end
                FLUSH_S: begin
                    redirect_valid_r <= 1'b0;
                    if (flush_cnt_r == '0) begin
                        flush_r <= 1'b0;
                        state_r <= RUN_S;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= RUN_S;
                    flush_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_resolved_r;
    logic [15:0] stat_mispredicts_r;

    // Saturating resolve / mispredict event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_resolved_r    <= 16'h0000;
            stat_mispredicts_r <= 16'h0000;
        end else if (!stall && (state_r == RUN_S)) begin
            if (accept_s && (stat_resolved_r != 16'hFFFF)) begin
                stat_resolved_r <= stat_resolved_r + 16'd1;
            end
            if (mispredict_s && (stat_mispredicts_r != 16'hFFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 16'd1;
            end
        end
    end

    assign stat_resolved    = stat_resolved_r;
    assign stat_mispredicts = stat_mispredicts_r;
`else
    assign stat_resolved    = 16'h0000;
    assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolution_controller.sv
// Directed self-checking bench for branch_resolution_controller.
module tb_branch_resolution_controller;

    logic        clk = 1'b0;
    logic        rst_n, stall, fetch_branch_valid, fetch_prediction;
    logic [15:0] fetch_alt_address;
    logic        resolve_valid, resolve_taken, q_prediction;
    logic [15:0] q_mispredict_address;
    logic        q_stall, q_load_prediction, q_update_predictions, q_correct_prediction;
    logic        q_prediction_in;
    logic [15:0] q_mispredict_address_in;
    logic        fetch_hold, redirect_valid, flush, protocol_err;
    logic [15:0] redirect_address, stat_resolved, stat_mispredicts;
    logic [1:0]  inflight_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolution_controller #(.DEPTH(3), .FLUSH_CYCLES(2)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .stall                   (stall),
        .fetch_branch_valid      (fetch_branch_valid),
        .fetch_prediction        (fetch_prediction),
        .fetch_alt_address       (fetch_alt_address),
        .resolve_valid           (resolve_valid),
        .resolve_taken           (resolve_taken),
        .q_prediction            (q_prediction),
        .q_mispredict_address    (q_mispredict_address),
        .q_stall                 (q_stall),
        .q_load_prediction       (q_load_prediction),
        .q_update_predictions    (q_update_predictions),
        .q_correct_prediction    (q_correct_prediction),
        .q_prediction_in         (q_prediction_in),
        .q_mispredict_address_in (q_mispredict_address_in),
        .fetch_hold              (fetch_hold),
        .redirect_valid          (redirect_valid),
        .redirect_address        (redirect_address),
        .flush                   (flush),
        .inflight_count          (inflight_count),
        .protocol_err            (protocol_err),
        .stat_resolved           (stat_resolved),
        .stat_mispredicts        (stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock; sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic rv, input logic rt, input logic qp);
        fetch_branch_valid = fv;
        resolve_valid      = rv;
        resolve_taken      = rt;
        q_prediction       = qp;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        fetch_prediction = 1'b1; fetch_alt_address = 16'hBEEF;
        q_mispredict_address = 16'h1234;
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // reset clear, two cycles
        check("rst_upd_c1", q_update_predictions, 1);
        check("rst_cor_c1", q_correct_prediction, 0);
        check("rst_load_c1", q_load_prediction, 0);
        step();
        check("rst_upd_c2", q_update_predictions, 1);
        check("rst_cor_c2", q_correct_prediction, 0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_count", inflight_count, 0);
        check("rst_flush", flush, 0);
        check("rst_redir", redirect_valid, 0);
        check("rst_perr", protocol_err, 0);
        check("pass_addr", q_mispredict_address_in, 16'hBEEF);

        // fill to full
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check("fill_load", q_load_prediction, 1);
            step();
            check("fill_count", inflight_count, i);
        end
        check("full_hold", fetch_hold, 1);
        check("full_load4", q_load_prediction, 0);
        step();
        check("full_count", inflight_count, 3);

        // full + correct resolve: load still blocked
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("fullres_load", q_load_prediction, 0);
        check("fullres_upd", q_update_predictions, 1);
        check("fullres_cor", q_correct_prediction, 1);
        step();
        check("fullres_count", inflight_count, 2);

        // correct resolve plus load at count 2
        check("rl_load", q_load_prediction, 1);
        check("rl_upd", q_update_predictions, 1);
        check("rl_cor", q_correct_prediction, 1);
        step();
        check("rl_count", inflight_count, 2);

        // mispredict with a same-cycle fetch
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("mp_cor", q_correct_prediction, 0);
        check("mp_load", q_load_prediction, 0);
        check("mp_upd", q_update_predictions, 1);
        step();
        check("mp_redir", redirect_valid, 1);
        check("mp_addr", redirect_address, 16'h1234);
        check("mp_flush1", flush, 1);
        check("mp_count", inflight_count, 0);
        check("fl_upd", q_update_predictions, 0);
        check("fl_load", q_load_prediction, 0);
        step();
        check("mp_redir_off", redirect_valid, 0);
        check("mp_flush2", flush, 1);
        step();
        check("mp_flush_end", flush, 0);
        check("fl_res_ign", protocol_err, 0);
        check("fl_cnt_ign", inflight_count, 0);

        // resolve while empty
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("empty_upd", q_update_predictions, 0);
        step();
        check("empty_perr", protocol_err, 1);
        check("empty_count", inflight_count, 0);

        // stall during flush extends it
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("st_count", inflight_count, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check("st_flush_a", flush, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        stall = 1'b1;
        #1;
        check("st_qstall", q_stall, 1);
        check("st_upd", q_update_predictions, 0);
        check("st_load", q_load_prediction, 0);
        step();
        check("st_flush_b", flush, 1);
        step();
        check("st_flush_c", flush, 1);
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("st_flush_d", flush, 1);
        step();
        check("st_flush_e", flush, 0);

        // reset mid flush
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check("rmf_flush_on", flush, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("rmf_flush", flush, 0);
        check("rmf_redir", redirect_valid, 0);
        check("rmf_perr", protocol_err, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("rmf_run_load", q_load_prediction, 1);
        step();
        check("rmf_count", inflight_count, 1);

        // stats: 5 resolves, 2 mispredicts
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1); step();
        drive(1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 1'b1, 1'b1, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0); step(); step();
        check("stat_mid_count", inflight_count, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 1'b1, 1'b0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0); step(); step();
        check("stat_flush_end", flush, 0);
`ifdef BRANCH_STATS_EN
        check("stat_res", stat_resolved, 5);
        check("stat_mis", stat_mispredicts, 2);
`else
        check("stat_res_off", stat_resolved, 0);
        check("stat_mis_off", stat_mispredicts, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
